// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : dm_responder
// Purpose  : Data-memory responder for the MEM stage of a 5-stage MIPS
//            pipeline. Accepts one load/store at a time over valid/ready,
//            models WAIT_CYC extra cycles of access latency, performs
//            little-endian byte/halfword/word lane selection with sign or
//            zero extension, and stalls the pipeline until the response.
// Ports    : clk        - clock
//            rst        - asynchronous reset, active low
//            req_valid  - request present (held until resp_valid)
//            req_ready  - responder idle and able to accept
//            req_op     - MIPS opcode (lb/lbu/lh/lhu/lw/sb/sh/sw)
//            req_addr   - byte address
//            req_wdata  - store data
//            resp_valid - one-cycle response strobe
//            resp_rdata - extended load data (0 for stores and errors)
//            resp_err   - misaligned or unsupported op
//            stall      - hold IF/ID/EX/MEM
// Revision : 1.0 - initial release
// ============================================================================
module dm_responder #(
  parameter int ADDR_W   = 12,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              stall
);

  localparam int DEPTH = 1 << (ADDR_W - 2);
  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC + 1) : 1;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              commit;
  logic [5:0]        c_op;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata;
  logic [31:0]       rd_word;
  logic [31:0]       wr_word;
  logic [31:0]       ld_data;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic              we;
  logic              err;

  // rst gates acceptance so nothing commits while reset is held.
  assign accept = (state == S_IDLE) && req_valid && rst;

  // With no wait cycles the commit happens on the accept edge itself, so the
  // live request inputs are used; otherwise the captured copy is used.
  assign commit  = (WAIT_CYC == 0) ? accept
                                   : ((state == S_WAIT) && (cnt == CNT_W'(1)));
  assign c_op    = (WAIT_CYC == 0) ? req_op    : op_q;
  assign c_addr  = (WAIT_CYC == 0) ? req_addr  : addr_q;
  assign c_wdata = (WAIT_CYC == 0) ? req_wdata : wdata_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid) state_nxt = (WAIT_CYC == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == CNT_W'(1)) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
    stall      = req_valid & ~resp_valid;
  end

  // ---------------- request capture and wait counter ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt     <= CNT_W'(WAIT_CYC);
      op_q    <= req_op;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end else if (state == S_WAIT) begin
      cnt     <= cnt - CNT_W'(1);
    end
  end

  // ---------------- lane selection and decode ----------------
  always_comb begin
    rd_word  = mem[c_addr[ADDR_W-1:2]];
    sel_byte = rd_word[{c_addr[1:0], 3'b000} +: 8];
    sel_half = rd_word[{c_addr[1], 4'b0000} +: 16];
    wr_word  = rd_word;
    ld_data  = '0;
    we       = 1'b0;
    err      = 1'b0;
    case (c_op)
      OP_LB:  ld_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU: ld_data = {24'b0, sel_byte};
      OP_LH:  if (c_addr[0]) err = 1'b1;
              else ld_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU: if (c_addr[0]) err = 1'b1;
              else ld_data = {16'b0, sel_half};
      OP_LW:  if (c_addr[1:0] != 2'b00) err = 1'b1;
              else ld_data = rd_word;
      OP_SB: begin
        we = 1'b1;
        wr_word[{c_addr[1:0], 3'b000} +: 8] = c_wdata[7:0];
      end
      OP_SH:  if (c_addr[0]) err = 1'b1;
              else begin
                we = 1'b1;
                wr_word[{c_addr[1], 4'b0000} +: 16] = c_wdata[15:0];
              end
      OP_SW:  if (c_addr[1:0] != 2'b00) err = 1'b1;
              else begin
                we      = 1'b1;
                wr_word = c_wdata;
              end
      default: err = 1'b1;
    endcase
  end

  // Storage is deliberately not reset; read-modify-write of whole words.
  always_ff @(posedge clk) begin
    if (commit && we) mem[c_addr[ADDR_W-1:2]] <= wr_word;
  end

  // Response data is loaded on the commit edge (which always enters RESP)
  // and cleared on every other edge, so it reads as zero outside RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (commit) begin
      rdata_q <= ld_data;
      err_q   <= err;
    end else begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_responder
// Purpose  : Self-checking bench for dm_responder. Two instances (WAIT_CYC=2
//            and WAIT_CYC=0) are driven with directed and random requests and
//            compared against a byte-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  req_op = '0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        v2 = 1'b0, v0 = 1'b0;
  logic        ready2, rv2, err2, st2;
  logic        ready0, rv0, err0, st0;
  logic [31:0] rd2, rd0;
  int          sel = 0;

  logic        cur_ready, cur_rv, cur_err, cur_st;
  logic [31:0] cur_rd;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] ref_mem [2][1024];

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(12), .WAIT_CYC(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_ready(ready2),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv2), .resp_rdata(rd2), .resp_err(err2), .stall(st2)
  );

  dm_responder #(.ADDR_W(12), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(ready0),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0), .stall(st0)
  );

  assign cur_ready = (sel == 0) ? ready2 : ready0;
  assign cur_rv    = (sel == 0) ? rv2    : rv0;
  assign cur_err   = (sel == 0) ? err2   : err0;
  assign cur_st    = (sel == 0) ? st2    : st0;
  assign cur_rd    = (sel == 0) ? rd2    : rd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-level reference: extract/insert lanes with shifts and masks.
  function automatic void model(input logic [5:0] op, input logic [11:0] a,
                                input logic [31:0] wd, input logic [31:0] old,
                                output logic [31:0] rd, output logic er,
                                output logic [31:0] nw);
    int n, h, b, hw;
    n  = int'(a[1:0]);
    h  = int'(a[1]);
    b  = int'((old >> (8 * n)) & 32'hFF);
    hw = int'((old >> (16 * h)) & 32'hFFFF);
    rd = '0; er = 1'b0; nw = old;
    case (op)
      6'h20: rd = 32'((b >= 128) ? b - 256 : b);
      6'h24: rd = 32'(b);
      6'h21: if (a[0]) er = 1'b1; else rd = 32'((hw >= 32768) ? hw - 65536 : hw);
      6'h25: if (a[0]) er = 1'b1; else rd = 32'(hw);
      6'h23: if (a[1:0] != 2'b00) er = 1'b1; else rd = old;
      6'h28: nw = (old & ~(32'hFF << (8 * n))) | ((wd & 32'hFF) << (8 * n));
      6'h29: if (a[0]) er = 1'b1;
             else nw = (old & ~(32'hFFFF << (16 * h))) | ((wd & 32'hFFFF) << (16 * h));
      6'h2B: if (a[1:0] != 2'b00) er = 1'b1; else nw = wd;
      default: er = 1'b1;
    endcase
  endfunction

  // Issue one request on instance s (0: WAIT_CYC=2, 1: WAIT_CYC=0), called
  // #1 after a rising edge with the DUT idle. Returns #1 after the edge that
  // ends the response cycle, so a following call is back-to-back.
  task automatic do_req(input int s, input logic [5:0] op, input logic [11:0] a,
                        input logic [31:0] wd, input string tag,
                        output logic [31:0] rd_out);
    logic [31:0] old, exp_rd, nw;
    logic        exp_err;
    int          wc, lat, stalls;
    bit          got;
    wc  = (s == 0) ? 2 : 0;
    old = ref_mem[s][a[11:2]];
    model(op, a, wd, old, exp_rd, exp_err, nw);
    sel = s;
    req_op = op; req_addr = a; req_wdata = wd;
    if (s == 0) v2 = 1'b1; else v0 = 1'b1;
    lat = -1; stalls = 0; got = 0; rd_out = '0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (cur_rv) begin
        got = 1; lat = c; rd_out = cur_rd;
        check({tag, " rdata"}, cur_rd, exp_rd);
        check({tag, " err"}, {31'b0, cur_err}, {31'b0, exp_err});
        check({tag, " ready_in_resp"}, {31'b0, cur_ready}, 32'd0);
        check({tag, " stall_in_resp"}, {31'b0, cur_st}, 32'd0);
      end else begin
        if (cur_st) stalls++;
        if (c == 0) check({tag, " ready_at_accept"}, {31'b0, cur_ready}, 32'd1);
      end
      @(posedge clk); #1;
    end
    if (s == 0) v2 = 1'b0; else v0 = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(wc + 1));
    check({tag, " stall_cycles"}, 32'(stalls), 32'(wc + 1));
    if (!exp_err) ref_mem[s][a[11:2]] = nw;
  endtask

  initial begin
    logic [31:0] r;
    logic [5:0]  ops [9];
    int          quiet;
    ops = '{6'h20, 6'h24, 6'h21, 6'h25, 6'h23, 6'h28, 6'h29, 6'h2B, 6'h3F};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready", {31'b0, ready2}, 32'd1);
    check("reset resp_valid", {31'b0, rv2}, 32'd0);
    check("reset rdata", rd2, 32'd0);
    check("reset err", {31'b0, err2}, 32'd0);
    check("reset stall", {31'b0, st2}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed, WAIT_CYC=2
    do_req(0, 6'h2B, 12'h010, 32'h8899AABB, "sw010", r);
    do_req(0, 6'h23, 12'h010, 32'h0, "lw010", r);
    check("lw010 const", r, 32'h8899AABB);
    do_req(0, 6'h20, 12'h013, 32'h0, "lb013", r);
    check("lb013 const", r, 32'hFFFFFF88);
    do_req(0, 6'h24, 12'h013, 32'h0, "lbu013", r);
    check("lbu013 const", r, 32'h00000088);
    do_req(0, 6'h21, 12'h012, 32'h0, "lh012", r);
    check("lh012 const", r, 32'hFFFF8899);
    do_req(0, 6'h25, 12'h010, 32'h0, "lhu010", r);
    check("lhu010 const", r, 32'h0000AABB);
    do_req(0, 6'h28, 12'h011, 32'h12345677, "sb011", r);
    do_req(0, 6'h29, 12'h012, 32'h0000CDEF, "sh012", r);
    do_req(0, 6'h23, 12'h010, 32'h0, "lw010b", r);
    check("merge const", r, 32'hCDEF77BB);
    do_req(0, 6'h23, 12'h011, 32'h0, "lw011", r);
    do_req(0, 6'h29, 12'h013, 32'hFFFFFFFF, "sh013", r);
    do_req(0, 6'h3F, 12'h010, 32'hFFFFFFFF, "op3F", r);
    do_req(0, 6'h23, 12'h010, 32'h0, "lw010c", r);
    check("unchanged const", r, 32'hCDEF77BB);

    // Directed, WAIT_CYC=0: back-to-back sw then lw
    do_req(1, 6'h2B, 12'h040, 32'hCAFEF00D, "w0 sw", r);
    do_req(1, 6'h23, 12'h040, 32'h0, "w0 lw", r);
    check("w0 lw const", r, 32'hCAFEF00D);

    // Reset during WAIT drops the uncommitted store
    do_req(0, 6'h2B, 12'h020, 32'h11112222, "sw020", r);
    sel = 0;
    req_op = 6'h2B; req_addr = 12'h020; req_wdata = 32'hDEADBEEF; v2 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; v2 = 1'b0;
    @(negedge clk);
    check("midrst ready", {31'b0, ready2}, 32'd1);
    check("midrst resp_valid", {31'b0, rv2}, 32'd0);
    check("midrst rdata", rd2, 32'd0);
    check("midrst err", {31'b0, err2}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    quiet = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rv2) quiet++;
    end
    check("postrst no resp", 32'(quiet), 32'd0);
    @(posedge clk); #1;
    do_req(0, 6'h23, 12'h020, 32'h0, "lw020", r);
    check("lw020 const", r, 32'h11112222);

    // Random traffic on a preinitialised window of 8 words per instance
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 8; w++)
        do_req(s, 6'h2B, 12'h100 + 12'(w * 4), $urandom, "init", r);
      for (int k = 0; k < 60; k++)
        do_req(s, ops[$urandom_range(0, 8)], 12'h100 + 12'($urandom_range(0, 31)),
               $urandom, "rand", r);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
